tt_um_projectdemux: RTL
=======================

Name: tt_um_projectdemux

Overview:
- 4-channel demultiplexer: the receive end of the 4:1 channel-select mux link.
- Receives one serial data bit per strobe and steers it to one of four latched output channels.
- Auto mode: slots are taken from a frame-synchronised time-division counter. Direct mode: the channel is chosen by an explicit 2-bit select.
- Sits as a Tiny Tapeout user project; all I/O goes through the standard tile pins.

Parameters:
- None. Channel count is fixed at 4 by the pin budget.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- ena  input  1  design enable; when low, all state holds
- ui_in  input  8  [0] data bit; [1] frame sync; [2] strobe; [3] mode (0=auto TDM, 1=direct); [5:4] direct-mode channel select; [6] sync_err clear; [7] unused
- uo_out  output  8  [3:0] channel outputs ch0..ch3; [5:4] current slot count; [6] frame_done pulse; [7] sync_err sticky flag
- uio_in  input  8  unused
- uio_out  output  8  tied to 0
- uio_oe  output  8  tied to 0 (all inputs)

Behaviour:
- Reset (rst_n low, asynchronous):
  - ch[3:0]=0, shadow[2:0]=0, slot=0, frame_done=0, sync_err=0.
  - Takes effect immediately, including mid-frame; the partial frame is discarded.
- ena=0: no register changes. frame_done is forced to 0 on the next edge.
- Inputs are treated as synchronous to clk. There is no synchroniser inside the block.
- A bit is consumed only on an edge where ena=1 and strobe=1. Without strobe, slot, ch and shadow hold.
- Auto mode (mode=0), on a consumed bit, effective slot s = (sync ? 0 : slot):
  - s<3: shadow[s] <= data; slot <= s+1.
  - s=3: ch <= {data, shadow[2:0]} atomically; slot <= 0; frame_done <= 1 for exactly one cycle.
  - Latency: ch and frame_done are visible the cycle after the strobe that carries the slot-3 bit.
  - sync=1 while slot!=0: sync_err <= 1 (sticky) and the counter realigns to slot 0. The bit is written to shadow[0]; stale shadow[1..2] are kept and get overwritten by later bits.
  - sync=1 while slot=0: normal, no error.
  - Wrap: slot 3->0 without sync is legal; sync is not required every frame.
- Direct mode (mode=1), on a consumed bit:
  - ch[sel] <= data immediately (visible next cycle); the other channels hold. Shadow is untouched.
  - slot is held at 0 on every edge while mode=1, strobe or not.
  - frame_done stays 0. sync is ignored and does not set sync_err.
- Mode change mid-frame (auto->direct): the partial frame is abandoned and slot is cleared. Returning to auto starts at slot 0.
- frame_done is otherwise 0 every cycle and is never asserted two cycles back-to-back.
- sync_err clear:
  - ui_in[6]=1 with ena=1 clears sync_err on the next edge.
  - If a new sync error occurs on the same edge, set wins.
- uo_out[5:4] reflects the registered slot value.
- Total flops: 4 ch + 3 shadow + 2 slot + frame_done + sync_err = 11.

Decomposition:
- Package tdm_demux_pkg:
  - NUM_CH=4, SLOT_W=2.
  - Localparams for ui_in/uo_out bit indices (DATA, SYNC, STB, MODE, SEL_LO/HI, CLR, FDONE, SERR).
  - Enum for mode (MODE_AUTO, MODE_DIRECT).
- One sub-module, tdm_demux_core: slot counter, shadow/ch registers, flags, with clean named ports.
- The top tt_um_projectdemux only maps pins, ties uio_out/uio_oe to 0, and gates with ena.

Test Plan:
- Reset: drive rst_n=0 mid-operation, asynchronously between edges -> uo_out=0x00 immediately. After release with no strobe, uo_out stays 0x00.
- Auto frame: mode=0, 4 strobes, data 1,0,1,1, sync=1 on the first -> cycle after the 4th strobe uo_out[3:0]=4'b1101 and [6]=1 for one cycle; slot returns to 0; ch unchanged during strobes 1-3.
- Sync error: after 2 bits of a frame, strobe with sync=1 -> uo_out[7]=1 and slot=1. Then 3 more bits 0,1,0 -> ch=4'b0100 with frame_done. Pulse ui_in[6] -> uo_out[7]=0.
- Direct mode: mode=1, sel=2 data=1 strobe, then sel=0 data=1 strobe -> uo_out[3:0]=4'b0101; [6] never 1; sync=1 with strobe leaves [7]=0.
- Gating/mode switch: ena=0 with strobes -> no change. Auto with 2 bits in, switch to direct for 1 cycle without strobe, back to auto -> slot=0; next 4 bits form a full frame.
- Simultaneous: sync error and ui_in[6]=1 on the same edge -> sync_err=1. Strobe deasserted between bits of a frame -> frame completes only after the 4th strobe.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared constants and types for the 4-channel TDM demultiplexer.
//
// Contents:
//   NUM_CH, SLOT_W          channel count and slot counter width
//   ui_in bit indices       DATA, SYNC, STB, MODE, SEL_LO/SEL_HI, CLR
//   uo_out bit indices      CH_LO/CH_HI, SLOT_LO/SLOT_HI, FDONE, SERR
//   mode_e                  MODE_AUTO (time-division slots), MODE_DIRECT (explicit select)
package tdm_demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SLOT_W = 2;

    // ui_in bit positions
    localparam int DATA   = 0;
    localparam int SYNC   = 1;
    localparam int STB    = 2;
    localparam int MODE   = 3;
    localparam int SEL_LO = 4;
    localparam int SEL_HI = 5;
    localparam int CLR    = 6;

    // uo_out bit positions
    localparam int CH_LO   = 0;
    localparam int CH_HI   = 3;
    localparam int SLOT_LO = 4;
    localparam int SLOT_HI = 5;
    localparam int FDONE   = 6;
    localparam int SERR    = 7;

    typedef enum logic {
        MODE_AUTO   = 1'b0,
        MODE_DIRECT = 1'b1
    } mode_e;

endpackage

// File: rtl/tdm_demux_if.sv
// Bundle between the pin-mapping top and the demux core.
//
// Handshake: there is no backpressure. A bit is transferred on every rising
// clock edge where stb=1 (and the core is enabled); the core is always ready.
// All other request fields (data, sync, mode, sel, clr) are sampled on that
// same edge.
//
// Signals:
//   data, sync, stb, mode, sel, clr   request side (master drives)
//   ch, slot, frame_done, sync_err    status side (slave drives)
// Modports:
//   master  drives the request side, observes status
//   slave   the core: observes requests, drives status
interface tdm_demux_if;
    import tdm_demux_pkg::*;

    logic                     data;
    logic                     sync;
    logic                     stb;
    mode_e                    mode;
    logic [SLOT_W-1:0]        sel;
    logic                     clr;

    logic [NUM_CH-1:0]        ch;
    logic [SLOT_W-1:0]        slot;
    logic                     frame_done;
    logic                     sync_err;

    modport master (
        output data, sync, stb, mode, sel, clr,
        input  ch, slot, frame_done, sync_err
    );

    modport slave (
        input  data, sync, stb, mode, sel, clr,
        output ch, slot, frame_done, sync_err
    );

endinterface

// File: rtl/tdm_demux_core.sv
// Demux core: slot counter, shadow register, latched channel outputs and the
// frame_done / sync_err flags.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   en      enable; when low nothing changes except frame_done dropping to 0
//   bus     tdm_demux_if.slave (request in, status out)
//
// Auto mode collects slots 0..2 in shadow and publishes all four channels at
// once when the slot-3 bit arrives, so the outputs never show a half frame.
module tdm_demux_core
    import tdm_demux_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    tdm_demux_if.slave   bus
);

    logic [NUM_CH-1:0] ch_q,     ch_d;
    logic [2:0]        shadow_q, shadow_d;
    logic [SLOT_W-1:0] slot_q,   slot_d;
    logic              fdone_q,  fdone_d;
    logic              serr_q,   serr_d;

    logic [SLOT_W-1:0] eff_slot;
    logic              err_set;

    always_comb begin
        ch_d     = ch_q;
        shadow_d = shadow_q;
        slot_d   = slot_q;
        fdone_d  = 1'b0;    // single-cycle pulse by construction
        serr_d   = serr_q;
        eff_slot = '0;
        err_set  = 1'b0;

        if (en) begin
            if (bus.mode == MODE_DIRECT) begin
                // Direct mode abandons any partial auto frame.
                slot_d = '0;
                if (bus.stb) begin
                    ch_d[bus.sel] = bus.data;
                end
            end else if (bus.stb) begin
                // sync realigns to slot 0; arriving mid-frame it is an error.
                eff_slot = bus.sync ? '0 : slot_q;
                err_set  = bus.sync && (slot_q != '0);
                case (eff_slot)
                    2'd0: begin shadow_d[0] = bus.data; slot_d = 2'd1; end
                    2'd1: begin shadow_d[1] = bus.data; slot_d = 2'd2; end
                    2'd2: begin shadow_d[2] = bus.data; slot_d = 2'd3; end
                    default: begin
                        ch_d    = {bus.data, shadow_q};
                        slot_d  = '0;
                        fdone_d = 1'b1;
                    end
                endcase
            end

            // A new error on the same edge as a clear keeps the flag set.
            if (err_set) begin
                serr_d = 1'b1;
            end else if (bus.clr) begin
                serr_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q     <= '0;
            shadow_q <= '0;
            slot_q   <= '0;
            fdone_q  <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            ch_q     <= ch_d;
            shadow_q <= shadow_d;
            slot_q   <= slot_d;
            fdone_q  <= fdone_d;
            serr_q   <= serr_d;
        end
    end

    assign bus.ch         = ch_q;
    assign bus.slot       = slot_q;
    assign bus.frame_done = fdone_q;
    assign bus.sync_err   = serr_q;

endmodule

// File: rtl/tt_um_projectdemux.sv
// Tiny Tapeout tile wrapper for the 4-channel TDM demultiplexer.
//
// Ports:
//   clk, rst_n, ena   standard tile clock, async active-low reset, enable
//   ui_in[0]  data      ui_in[1]  frame sync    ui_in[2] strobe
//   ui_in[3]  mode      ui_in[5:4] direct sel   ui_in[6] sync_err clear
//   uo_out[3:0] ch0..ch3   uo_out[5:4] slot   uo_out[6] frame_done
//   uo_out[7]   sync_err
//   uio_*     unused; uio_out and uio_oe tied low
module tt_um_projectdemux
    import tdm_demux_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    tdm_demux_if core_bus ();

    assign core_bus.data = ui_in[DATA];
    assign core_bus.sync = ui_in[SYNC];
    assign core_bus.stb  = ui_in[STB];
    assign core_bus.mode = mode_e'(ui_in[MODE]);
    assign core_bus.sel  = ui_in[SEL_HI:SEL_LO];
    assign core_bus.clr  = ui_in[CLR];

    tdm_demux_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ena),
        .bus   (core_bus.slave)
    );

    assign uo_out[CH_HI:CH_LO]     = core_bus.ch;
    assign uo_out[SLOT_HI:SLOT_LO] = core_bus.slot;
    assign uo_out[FDONE]           = core_bus.frame_done;
    assign uo_out[SERR]            = core_bus.sync_err;

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    wire unused_pins = &{1'b0, ui_in[7], uio_in};

endmodule
